mem_req_arbiter: RTL

- Arbitrates the instruction-fetch and data-memory sram-like request ports onto one shared sram-like master port, which drives the cache/AXI bridge.
- Only one transaction is outstanding at a time.
- The data side has priority.
- addr_ok and data_ok are routed back only to the requester that won the grant.
- Sits between the pipeline's fetch/mem stages and the bus bridge; the pipeline stalls on the missing ok pulses.

---
 rtl/mem_req_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// ============================================================================
// Module   : mem_req_arbiter
// Purpose  : Data-priority arbiter merging fetch and data sram-like ports onto
//            one master port, one transaction outstanding at a time.
//            Optional macro ARB_FAIRNESS_EN bounds consecutive data grants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_ownerData;
    logic              r_busReq;
    logic              r_busWr;
    logic [1:0]        r_busSize;
    logic [ADDR_W-1:0] r_busAddr;
    logic [DATA_W-1:0] r_busWdata;

    logic              w_forceInst;
    logic              w_grantData;
    logic              w_grantInst;
    logic              w_complete;

    generate
        if (MAX_DATA_RUN < 1) begin : g_paramCheck
            $error("MAX_DATA_RUN must be at least 1");
        end
    endgenerate

`ifdef ARB_FAIRNESS_EN
    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] c_MAX_RUN = RUN_W'(MAX_DATA_RUN);

    logic [RUN_W-1:0] r_runCnt;

    // Counts data grants that overtook a waiting fetch; cleared once fetch wins or stops asking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_runCnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_grantInst || !inst_req) begin
                r_runCnt <= '0;
            end else if (w_grantData) begin
                r_runCnt <= r_runCnt + RUN_W'(1);
            end
        end
    end

    assign w_forceInst = inst_req && (r_runCnt == c_MAX_RUN);
`else
    assign w_forceInst = 1'b0;
`endif

    always_comb begin
        w_grantData = 1'b0;
        w_grantInst = 1'b0;
        if (r_state == ST_IDLE) begin
            if (data_req && !w_forceInst) begin
                w_grantData = 1'b1;
            end else if (inst_req) begin
                w_grantInst = 1'b1;
            end
        end
    end

    // A REQ cycle with both handshakes completes exactly like a WAIT completion.
    assign w_complete = ((r_state == ST_REQ)  && bus_addr_ok && bus_data_ok) ||
                        ((r_state == ST_WAIT) && bus_data_ok);

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grantData || w_grantInst) begin
                    w_stateNext = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_addr_ok) begin
                    w_stateNext = bus_data_ok ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus_data_ok) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ownerData <= 1'b1;
            r_busReq    <= 1'b0;
            r_busWr     <= 1'b0;
            r_busSize   <= 2'd0;
            r_busAddr   <= '0;
            r_busWdata  <= '0;
        end else begin
            if (w_grantData) begin
                r_ownerData <= 1'b1;
                r_busReq    <= 1'b1;
                r_busWr     <= data_wr;
                r_busSize   <= data_size;
                r_busAddr   <= data_addr;
                r_busWdata  <= data_wdata;
            end else if (w_grantInst) begin
                r_ownerData <= 1'b0;
                r_busReq    <= 1'b1;
                r_busWr     <= inst_wr;
                r_busSize   <= inst_size;
                r_busAddr   <= inst_addr;
                r_busWdata  <= inst_wdata;
            end else if ((r_state == ST_REQ) && bus_addr_ok) begin
                r_busReq    <= 1'b0;
            end
        end
    end

    assign inst_addr_ok = w_grantInst;
    assign data_addr_ok = w_grantData;
    assign inst_data_ok = w_complete && !r_ownerData;
    assign data_data_ok = w_complete &&  r_ownerData;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    assign bus_req   = r_busReq;
    assign bus_wr    = r_busWr;
    assign bus_size  = r_busSize;
    assign bus_addr  = r_busAddr;
    assign bus_wdata = r_busWdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
